spectrum_peak_finder: RTL and testbench



---
 rtl/sdft_peak_pkg.sv | 20 ++
 rtl/bin_mag.sv | 71 +++++++
 rtl/spectrum_peak_finder.sv | 198 +++++++++++++++++++
 tb/tb_spectrum_peak_finder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdft_peak_pkg.sv
// Shared types and helpers for the spectrum peak finder.
package sdft_peak_pkg;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_GOOD,
    TAG_ERR
  } end_tag_t;

  // Bin index width that never collapses to zero bits.
  function automatic int unsigned bin_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bin_mag.sv
// Two-stage per-bin magnitude estimate: S1 registers |re|,|im|, S2 registers the combined magnitude.
// PEAK_ALPHA_MAX_BETA_MIN_EN selects max + 3/8*min instead of |re| + |im|.
module bin_mag
  import sdft_peak_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned MW = DW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid,
  input  logic [2*DW-1:0] data,
  output logic            out_valid,
  output logic [MW-1:0]   mag
);

  logic [DW-1:0] re;
  logic [DW-1:0] im;
  logic [DW-1:0] abs_re;
  logic [DW-1:0] abs_im;
  logic [DW-1:0] abs_re_q;
  logic [DW-1:0] abs_im_q;
  logic          s1_valid_q;
  logic [MW-1:0] mag_d;

  assign re = data[DW-1:0];
  assign im = data[2*DW-1:DW];

  // Most negative input maps to 2^(DW-1), which still fits unsigned DW bits.
  always_comb begin
    abs_re = re[DW-1] ? ((~re) + DW'(1)) : re;
    abs_im = im[DW-1] ? ((~im) + DW'(1)) : im;
  end

`ifdef PEAK_ALPHA_MAX_BETA_MIN_EN
  logic [DW-1:0] mx;
  logic [DW-1:0] mn;

  always_comb begin
    if (abs_re_q > abs_im_q) begin
      mx = abs_re_q;
      mn = abs_im_q;
    end else begin
      mx = abs_im_q;
      mn = abs_re_q;
    end
    mag_d = MW'(mx) + MW'(mn >> 2) + MW'(mn >> 3);
  end
`else
  always_comb begin
    mag_d = MW'(abs_re_q) + MW'(abs_im_q);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      abs_re_q   <= '0;
      abs_im_q   <= '0;
      out_valid  <= 1'b0;
      mag        <= '0;
    end else begin
      s1_valid_q <= in_valid;
      abs_re_q   <= abs_re;
      abs_im_q   <= abs_im;
      out_valid  <= s1_valid_q;
      mag        <= mag_d;
    end
  end

endmodule

// File: rtl/spectrum_peak_finder.sv
// Per-frame peak search over a windowed complex bin stream; reports peak bin/magnitude or a
// malformed-frame strobe. Build option PEAK_ALPHA_MAX_BETA_MIN_EN selects the magnitude estimate.
module spectrum_peak_finder
  import sdft_peak_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned N_BINS = 256,
  parameter int unsigned BIN_W  = bin_w(N_BINS),
  parameter int unsigned MW     = DW + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [2*DW-1:0]   data_i,
  input  logic              sob_i,
  input  logic              eob_i,
  input  logic              valid_i,
  input  logic [MW-1:0]     thr_i,
  output logic [BIN_W-1:0]  peak_bin_o,
  output logic [MW-1:0]     peak_mag_o,
  output logic              peak_found_o,
  output logic              peak_valid_o,
  output logic              frame_err_o
);

  localparam logic [BIN_W-1:0] LastBin = BIN_W'(N_BINS - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] cnt_q, cnt_d;
  logic             beat_take;
  logic             beat_sob;
  logic [BIN_W-1:0] beat_bin;
  end_tag_t         beat_tag;

  // Framing FSM runs on the raw input beat; its verdict travels down the pipe as a tag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beat_take = 1'b0;
    beat_sob  = 1'b0;
    beat_bin  = '0;
    beat_tag  = TAG_NONE;
    if (valid_i) begin
      unique case (state_q)
        IDLE: begin
          if (sob_i) begin
            beat_take = 1'b1;
            beat_sob  = 1'b1;
            cnt_d     = '0;
            if (eob_i) begin
              beat_tag = TAG_ERR;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          beat_take = 1'b1;
          if (sob_i) begin
            // Restart: the sob beat itself carries the error for the abandoned frame.
            beat_sob = 1'b1;
            beat_tag = TAG_ERR;
            cnt_d    = '0;
            if (eob_i) begin
              state_d = IDLE;
            end
          end else begin
            beat_bin = cnt_q + BIN_W'(1);
            cnt_d    = beat_bin;
            if (eob_i) begin
              beat_tag = (beat_bin == LastBin) ? TAG_GOOD : TAG_ERR;
              state_d  = IDLE;
            end else if (beat_bin == LastBin) begin
              beat_tag = TAG_ERR;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Input register: beat data plus its framing tags.
  logic             s0_valid_q;
  logic             s0_sob_q;
  end_tag_t         s0_tag_q;
  logic [BIN_W-1:0] s0_bin_q;
  logic [MW-1:0]    s0_thr_q;
  logic [2*DW-1:0]  s0_data_q;

  logic             s1_sob_q, s2_sob_q;
  end_tag_t         s1_tag_q, s2_tag_q;
  logic [BIN_W-1:0] s1_bin_q, s2_bin_q;
  logic [MW-1:0]    s1_thr_q, s2_thr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid_q <= 1'b0;
      s0_sob_q   <= 1'b0;
      s0_tag_q   <= TAG_NONE;
      s0_bin_q   <= '0;
      s0_thr_q   <= '0;
      s0_data_q  <= '0;
      s1_sob_q   <= 1'b0;
      s1_tag_q   <= TAG_NONE;
      s1_bin_q   <= '0;
      s1_thr_q   <= '0;
      s2_sob_q   <= 1'b0;
      s2_tag_q   <= TAG_NONE;
      s2_bin_q   <= '0;
      s2_thr_q   <= '0;
    end else begin
      s0_valid_q <= beat_take;
      s0_sob_q   <= beat_sob;
      s0_tag_q   <= beat_tag;
      s0_bin_q   <= beat_bin;
      s0_thr_q   <= thr_i;
      s0_data_q  <= data_i;
      s1_sob_q   <= s0_sob_q;
      s1_tag_q   <= s0_tag_q;
      s1_bin_q   <= s0_bin_q;
      s1_thr_q   <= s0_thr_q;
      s2_sob_q   <= s1_sob_q;
      s2_tag_q   <= s1_tag_q;
      s2_bin_q   <= s1_bin_q;
      s2_thr_q   <= s1_thr_q;
    end
  end

  logic          s2_valid;
  logic [MW-1:0] s2_mag;

  bin_mag #(
    .DW (DW),
    .MW (MW)
  ) u_bin_mag (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (s0_valid_q),
    .data      (s0_data_q),
    .out_valid (s2_valid),
    .mag       (s2_mag)
  );

  // S3: running max; sob reloads unconditionally, otherwise strictly greater wins.
  logic [MW-1:0]    max_mag_q, max_mag_d;
  logic [BIN_W-1:0] max_bin_q, max_bin_d;

  always_comb begin
    max_mag_d = max_mag_q;
    max_bin_d = max_bin_q;
    if (s2_valid) begin
      if (s2_sob_q) begin
        max_mag_d = s2_mag;
        max_bin_d = '0;
      end else if (s2_mag > max_mag_q) begin
        max_mag_d = s2_mag;
        max_bin_d = s2_bin_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      max_mag_q    <= '0;
      max_bin_q    <= '0;
      peak_bin_o   <= '0;
      peak_mag_o   <= '0;
      peak_found_o <= 1'b0;
      peak_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
    end else begin
      max_mag_q    <= max_mag_d;
      max_bin_q    <= max_bin_d;
      peak_valid_o <= 1'b0;
      frame_err_o  <= 1'b0;
      if (s2_valid && (s2_tag_q == TAG_GOOD)) begin
        peak_valid_o <= 1'b1;
        peak_bin_o   <= max_bin_d;
        peak_mag_o   <= max_mag_d;
        peak_found_o <= (max_mag_d > s2_thr_q);
      end else if (s2_valid && (s2_tag_q == TAG_ERR)) begin
        frame_err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Self-checking bench for spectrum_peak_finder (N_BINS = 8): frame table plus framing corner cases.
module tb_spectrum_peak_finder;

  localparam int unsigned DW = 16;
  localparam int unsigned NB = 8;
  localparam int unsigned BW = 3;
  localparam int unsigned MW = 17;
  localparam int unsigned NV = 9;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic [2*DW-1:0] data_i = '0;
  logic            sob_i = 1'b0;
  logic            eob_i = 1'b0;
  logic            valid_i = 1'b0;
  logic [MW-1:0]   thr_i = '0;
  logic [BW-1:0]   peak_bin_o;
  logic [MW-1:0]   peak_mag_o;
  logic            peak_found_o;
  logic            peak_valid_o;
  logic            frame_err_o;

  spectrum_peak_finder #(
    .DW     (DW),
    .N_BINS (NB)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .data_i       (data_i),
    .sob_i        (sob_i),
    .eob_i        (eob_i),
    .valid_i      (valid_i),
    .thr_i        (thr_i),
    .peak_bin_o   (peak_bin_o),
    .peak_mag_o   (peak_mag_o),
    .peak_found_o (peak_found_o),
    .peak_valid_o (peak_valid_o),
    .frame_err_o  (frame_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [NB-1:0][DW-1:0] re;
    logic [NB-1:0][DW-1:0] im;
    logic [MW-1:0]         thr;
    logic [BW-1:0]         bin;
    logic [MW-1:0]         mag;
    logic                  found;
    logic [3:0]            gap;   // bin before which a valid-low beat is inserted; 15 = none
  } vec_t;

  typedef struct packed {
    logic          err;
    logic [BW-1:0] bin;
    logic [MW-1:0] mag;
    logic          found;
    logic [31:0]   due;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb [$];
  exp_t ex;

  int n_cmp = 0;
  int n_bad = 0;

  logic [BW-1:0] last_bin = '0;
  logic [MW-1:0] last_mag = '0;
  logic          last_found = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  task automatic push(input logic err, input logic [BW-1:0] bin, input logic [MW-1:0] mag,
                      input logic found, input int t);
    exp_t x;
    x.err   = err;
    x.bin   = bin;
    x.mag   = mag;
    x.found = found;
    x.due   = 32'(t + 3);
    sb.push_back(x);
  endtask

  // Drives one beat; t returns the cycle index of the edge that sampled it.
  task automatic beat(input logic v, input logic s, input logic e, input logic [DW-1:0] re,
                      input logic [DW-1:0] im, input logic [MW-1:0] thr, output int t);
    valid_i = v;
    sob_i   = s;
    eob_i   = e;
    data_i  = {im, re};
    thr_i   = thr;
    @(posedge clk);
    #1;
    t       = cyc;
    valid_i = 1'b0;
    sob_i   = 1'b0;
    eob_i   = 1'b0;
  endtask

  task automatic send_frame(input int idx, input logic err_first);
    int t;
    for (int b = 0; b < int'(NB); b++) begin
      if (int'(vecs[idx].gap) == b) beat(1'b0, 1'b1, 1'b1, 16'h7fff, 16'h7fff, '0, t);
      beat(1'b1, b == 0, b == int'(NB) - 1, vecs[idx].re[b], vecs[idx].im[b], vecs[idx].thr, t);
      if (b == 0 && err_first) push(1'b1, '0, '0, 1'b0, t);
      if (b == int'(NB) - 1) push(1'b0, vecs[idx].bin, vecs[idx].mag, vecs[idx].found, t);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_i && (peak_valid_o || frame_err_o)) begin
      chk("strobe_exclusive", 32'(peak_valid_o & frame_err_o), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({peak_valid_o, frame_err_o}), 32'd0);
      end else begin
        ex = sb.pop_front();
        chk("strobe_kind", 32'({peak_valid_o, frame_err_o}), ex.err ? 32'd1 : 32'd2);
        chk("strobe_cycle", 32'(cyc), ex.due);
        if (!ex.err) begin
          chk("peak_bin", 32'(peak_bin_o), 32'(ex.bin));
          chk("peak_mag", 32'(peak_mag_o), 32'(ex.mag));
          chk("peak_found", 32'(peak_found_o), 32'(ex.found));
          last_bin   = ex.bin;
          last_mag   = ex.mag;
          last_found = ex.found;
        end else begin
          chk("hold_bin", 32'(peak_bin_o), 32'(last_bin));
          chk("hold_mag", 32'(peak_mag_o), 32'(last_mag));
          chk("hold_found", 32'(peak_found_o), 32'(last_found));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < int'(NV); i++) begin
      vecs[i]     = '0;
      vecs[i].gap = 4'hf;
    end
    // 0: ramp, thr 50
    vecs[0].re    = {16'd1, 16'd2, 16'd3, 16'd100, 16'd3, 16'd2, 16'd1, 16'd0};
    vecs[0].thr   = 17'd50;
    vecs[0].bin   = 3'd4;
    vecs[0].mag   = 17'd100;
    vecs[0].found = 1'b1;
    // 1: ramp, thr equal to the peak, with a valid-low beat mid-frame
    vecs[1]       = vecs[0];
    vecs[1].thr   = 17'd100;
    vecs[1].found = 1'b0;
    vecs[1].gap   = 4'd3;
    // 2: most negative re against most positive re, im = -1 at both
    vecs[2].re[2] = 16'h8000;
    vecs[2].im[2] = 16'hffff;
    vecs[2].re[6] = 16'h7fff;
    vecs[2].im[6] = 16'hffff;
    vecs[2].bin   = 3'd2;
`ifdef PEAK_ALPHA_MAX_BETA_MIN_EN
    vecs[2].mag   = 17'd32768;
`else
    vecs[2].mag   = 17'd32769;
`endif
    vecs[2].found = 1'b1;
    // 3: equal magnitudes at bins 1 and 5, lower index wins
    vecs[3].re    = {16'd7, 16'd7, 16'hfe0c, 16'd7, 16'd7, 16'd7, 16'd500, 16'd7};
    vecs[3].thr   = 17'd499;
    vecs[3].bin   = 3'd1;
    vecs[3].mag   = 17'd500;
    vecs[3].found = 1'b1;
    // 4: all-zero frame, with a valid-low beat before bin 6
    vecs[4].gap   = 4'd6;
    // 5: peak on the eob beat itself
    vecs[5].re    = {16'd77, 16'd76, 16'd76, 16'd76, 16'd76, 16'd76, 16'd76, 16'd76};
    vecs[5].thr   = 17'd10;
    vecs[5].bin   = 3'd7;
    vecs[5].mag   = 17'd77;
    vecs[5].found = 1'b1;
    // 6: peak on the sob beat
    vecs[6].re    = {16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd5, 16'd1234};
    vecs[6].thr   = 17'd2000;
    vecs[6].bin   = 3'd0;
    vecs[6].mag   = 17'd1234;
    vecs[6].found = 1'b0;
    // 7: re 100, im 80 at bin 3
    vecs[7].re[3] = 16'd100;
    vecs[7].im[3] = 16'd80;
    vecs[7].thr   = 17'd150;
    vecs[7].bin   = 3'd3;
`ifdef PEAK_ALPHA_MAX_BETA_MIN_EN
    vecs[7].mag   = 17'd130;
    vecs[7].found = 1'b0;
`else
    vecs[7].mag   = 17'd180;
    vecs[7].found = 1'b1;
`endif
    // 8: both components at the negative extreme
    vecs[8].re[5] = 16'h8000;
    vecs[8].im[5] = 16'h8000;
    vecs[8].thr   = 17'd65535;
    vecs[8].bin   = 3'd5;
`ifdef PEAK_ALPHA_MAX_BETA_MIN_EN
    vecs[8].mag   = 17'd45056;
    vecs[8].found = 1'b0;
`else
    vecs[8].mag   = 17'd65536;
    vecs[8].found = 1'b1;
`endif

    // Outputs during reset
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bin", 32'(peak_bin_o), 32'd0);
    chk("reset_mag", 32'(peak_mag_o), 32'd0);
    chk("reset_found", 32'(peak_found_o), 32'd0);
    chk("reset_valid", 32'(peak_valid_o), 32'd0);
    chk("reset_err", 32'(frame_err_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    // Table frames, back to back with zero gap (frames 5,6,7 give peaks at bins 7,0,3)
    for (int i = 0; i < int'(NV); i++) send_frame(i, 1'b0);
    drain();

    // eob at bin 5
    for (int b = 0; b < 6; b++) begin
      beat(1'b1, b == 0, b == 5, 16'(b * 10 + 1), 16'd0, 17'd0, t);
    end
    push(1'b1, '0, '0, 1'b0, t);
    drain();

    // sob at bin 3, then a complete good frame
    for (int b = 0; b < 3; b++) beat(1'b1, b == 0, 1'b0, 16'd900, 16'd0, 17'd0, t);
    send_frame(0, 1'b1);
    drain();

    // 8 beats with no eob, then an orphan eob beat in IDLE that must be dropped silently
    for (int b = 0; b < int'(NB); b++) beat(1'b1, b == 0, 1'b0, 16'd3, 16'd3, 17'd0, t);
    push(1'b1, '0, '0, 1'b0, t);
    beat(1'b1, 1'b0, 1'b1, 16'd999, 16'd0, 17'd0, t);
    drain();

    // sob and eob on the same beat
    beat(1'b1, 1'b1, 1'b1, 16'd42, 16'd0, 17'd0, t);
    push(1'b1, '0, '0, 1'b0, t);
    drain();

    // Reset at bin 4 of a frame, then a fresh frame
    for (int b = 0; b < 4; b++) beat(1'b1, b == 0, 1'b0, vecs[2].re[b], vecs[2].im[b], '0, t);
    rst_i   = 1'b1;
    valid_i = 1'b1;
    data_i  = {16'd0, 16'd4000};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("midrst_bin", 32'(peak_bin_o), 32'd0);
      chk("midrst_mag", 32'(peak_mag_o), 32'd0);
      chk("midrst_found", 32'(peak_found_o), 32'd0);
      chk("midrst_valid", 32'(peak_valid_o), 32'd0);
      chk("midrst_err", 32'(frame_err_o), 32'd0);
    end
    valid_i    = 1'b0;
    rst_i      = 1'b0;
    last_bin   = '0;
    last_mag   = '0;
    last_found = 1'b0;
    send_frame(6, 1'b0);
    drain();

    repeat (10) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
